// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: CSR addresses, mstatus bit positions, exception cause codes,
// the sequencer state encoding and the two mstatus rewrite helpers shared by
// the trap sequencer.
package trap_ctrl_pkg;

    // CSR addresses touched by the trap/mret sequences
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // mstatus bit positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MSTATUS_MPP_LO = 11;

    // synchronous exception cause codes raised by execute
    localparam logic [3:0] EXC_ILLEGAL    = 4'd2;
    localparam logic [3:0] EXC_BREAKPOINT = 4'd3;
    localparam logic [3:0] EXC_ECALL      = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T_MEPC,
        ST_T_MCAUSE,
        ST_T_MSTATUS,
        ST_T_JUMP,
        ST_R_RD,
        ST_R_WR,
        ST_R_JUMP
    } trap_state_e;

    // Trap entry: stack MIE into MPIE, disable interrupts, record M-mode in MPP.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
        logic [31:0] v_ms;
        v_ms                                = ms;
        v_ms[MSTATUS_MPIE]                  = ms[MSTATUS_MIE];
        v_ms[MSTATUS_MIE]                   = 1'b0;
        v_ms[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return v_ms;
    endfunction

    // mret: restore MIE from MPIE and set MPIE.
    function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
        logic [31:0] v_ms;
        v_ms               = ms;
        v_ms[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
        v_ms[MSTATUS_MPIE] = 1'b1;
        return v_ms;
    endfunction

endpackage

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer. Owns the CSR file's single read and
// write ports, sequences mepc/mcause/mstatus updates for exceptions, the timer
// interrupt and mret, and produces the PC redirect. Core CSR accesses pass
// through only while idle; otherwise the pipeline is held.
// Optional build macro TRAP_VECTORED_EN: interrupts with mtvec mode 2'b01 jump
// to base + IRQ_CAUSE[3:0]*4; without it every trap uses the base address.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter logic [31:0] IRQ_CAUSE = 32'h8000_0007,
    parameter int          XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exc_valid,
    input  logic [3:0]      exc_code,
    input  logic [XLEN-1:0] exc_pc,
    input  logic            mret_valid,
    input  logic            irq,
    input  logic [XLEN-1:0] irq_pc,
    input  logic            glb_int_en,
    input  logic [11:0]     core_csr_rdaddr,
    output logic [XLEN-1:0] core_csr_rddata,
    input  logic            core_csr_wren,
    input  logic [11:0]     core_csr_wraddr,
    input  logic [XLEN-1:0] core_csr_wrdata,
    output logic [11:0]     csr_rdaddr,
    input  logic [XLEN-1:0] csr_rddata,
    output logic            csr_wren,
    output logic [11:0]     csr_wraddr,
    output logic [XLEN-1:0] csr_wrdata,
    output logic            hold,
    output logic            jump_en,
    output logic [XLEN-1:0] jump_addr
);

    trap_state_e     r_state;
    trap_state_e     w_next_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_mstatus;
    logic [XLEN-1:2] r_mtvec_base;
    logic [XLEN-1:0] r_jump_addr;
    logic            w_idle;
    logic            w_take_exc;
    logic            w_take_mret;
    logic            w_take_irq;
    logic            w_take;
    logic [XLEN-1:0] w_trap_base;
    logic [XLEN-1:0] w_trap_target;

    // Requests are only looked at in IDLE; exception beats mret beats interrupt.
    assign w_idle      = (r_state == ST_IDLE);
    assign w_take_exc  = w_idle & exc_valid;
    assign w_take_mret = w_idle & ~exc_valid & mret_valid;
    assign w_take_irq  = w_idle & ~exc_valid & ~mret_valid & irq & glb_int_en;
    assign w_take      = w_take_exc | w_take_mret | w_take_irq;

    assign hold            = ~w_idle | w_take;
    assign core_csr_rddata = csr_rddata;
    assign w_trap_base     = {r_mtvec_base, 2'b00};

`ifdef TRAP_VECTORED_EN
    logic r_vec_irq;

    // Remember whether this trap is an interrupt taken through a vectored mtvec.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec_irq <= 1'b0;
        end else if (w_take) begin
            r_vec_irq <= w_take_irq;
        end else if (r_state == ST_T_MSTATUS) begin
            r_vec_irq <= r_vec_irq & (csr_rddata[1:0] == 2'b01);
        end
    end

    assign w_trap_target = r_vec_irq
        ? w_trap_base + {{(XLEN-6){1'b0}}, IRQ_CAUSE[3:0], 2'b00}
        : w_trap_base;
`else
    assign w_trap_target = w_trap_base;
`endif

    // State register; reset aborts any sequence in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking (<=) so every flop samples pre-edge values.
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture trap pc/cause on take, mstatus and mtvec as their reads return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= '0;
            r_cause      <= '0;
            r_mstatus    <= '0;
            r_mtvec_base <= '0;
        end else begin
            if (w_take_exc | w_take_irq) begin
                r_pc    <= w_take_exc ? exc_pc : irq_pc;
                r_cause <= w_take_exc ? {{(XLEN-4){1'b0}}, exc_code} : IRQ_CAUSE;
            end
            if (r_state == ST_T_MCAUSE || r_state == ST_R_WR) begin
                r_mstatus <= csr_rddata;
            end
            if (r_state == ST_T_MSTATUS) begin
                r_mtvec_base <= csr_rddata[XLEN-1:2];
            end
        end
    end

    // Keep the last redirect target visible between jumps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_jump_addr <= '0;
        end else if (jump_en) begin
            r_jump_addr <= jump_addr;
        end
    end

    // Next state plus CSR port mux: core pass-through in idle, sequence otherwise.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_next_state = r_state;
        csr_rdaddr   = core_csr_rdaddr;
        csr_wren     = 1'b0;
        csr_wraddr   = core_csr_wraddr;
        csr_wrdata   = core_csr_wrdata;
        jump_en      = 1'b0;
        jump_addr    = r_jump_addr;

        case (r_state)
            ST_IDLE: begin
                if (w_take_exc | w_take_irq) begin
                    w_next_state = ST_T_MEPC;
                end else if (w_take_mret) begin
                    w_next_state = ST_R_RD;
                end else begin
                    csr_wren = core_csr_wren;
                end
            end
            ST_T_MEPC: begin
                csr_wren     = 1'b1;
                csr_wraddr   = CSR_MEPC;
                csr_wrdata   = r_pc;
                csr_rdaddr   = CSR_MSTATUS;
                w_next_state = ST_T_MCAUSE;
            end
            ST_T_MCAUSE: begin
                csr_wren     = 1'b1;
                csr_wraddr   = CSR_MCAUSE;
                csr_wrdata   = r_cause;
                csr_rdaddr   = CSR_MTVEC;
                w_next_state = ST_T_MSTATUS;
            end
            ST_T_MSTATUS: begin
                csr_wren     = 1'b1;
                csr_wraddr   = CSR_MSTATUS;
                csr_wrdata   = trap_mstatus(r_mstatus);
                w_next_state = ST_T_JUMP;
            end
            ST_T_JUMP: begin
                jump_en      = 1'b1;
                jump_addr    = w_trap_target;
                w_next_state = ST_IDLE;
            end
            ST_R_RD: begin
                csr_rdaddr   = CSR_MSTATUS;
                w_next_state = ST_R_WR;
            end
            ST_R_WR: begin
                csr_wren     = 1'b1;
                csr_wraddr   = CSR_MSTATUS;
                csr_wrdata   = mret_mstatus(csr_rddata);
                csr_rdaddr   = CSR_MEPC;
                w_next_state = ST_R_JUMP;
            end
            ST_R_JUMP: begin
                jump_en      = 1'b1;
                jump_addr    = csr_rddata & ~32'h3;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: self-checking bench for trap_ctrl. A small registered-read CSR
// file sits behind the DUT's CSR ports. Idle pass-through and take cycles are
// table-driven, the multi-cycle sequences are hand-written, and random
// episodes are compared with a transaction-level model of each sequence.
`timescale 1ns/1ps
module tb_trap_ctrl;

    localparam logic [31:0] IRQ_CAUSE  = 32'h8000_0007;
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;

    logic        clk;
    logic        rst_n;
    logic        exc_valid;
    logic [3:0]  exc_code;
    logic [31:0] exc_pc;
    logic        mret_valid;
    logic        irq;
    logic [31:0] irq_pc;
    logic        glb_int_en;
    logic [11:0] core_csr_rdaddr;
    logic [31:0] core_csr_rddata;
    logic        core_csr_wren;
    logic [11:0] core_csr_wraddr;
    logic [31:0] core_csr_wrdata;
    logic [11:0] csr_rdaddr;
    logic [31:0] csr_rddata;
    logic        csr_wren;
    logic [11:0] csr_wraddr;
    logic [31:0] csr_wrdata;
    logic        hold;
    logic        jump_en;
    logic [31:0] jump_addr;

    int n_checks;
    int n_errors;

    trap_ctrl #(.IRQ_CAUSE(IRQ_CAUSE), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
        .mret_valid(mret_valid), .irq(irq), .irq_pc(irq_pc), .glb_int_en(glb_int_en),
        .core_csr_rdaddr(core_csr_rdaddr), .core_csr_rddata(core_csr_rddata),
        .core_csr_wren(core_csr_wren), .core_csr_wraddr(core_csr_wraddr),
        .core_csr_wrdata(core_csr_wrdata),
        .csr_rdaddr(csr_rdaddr), .csr_rddata(csr_rddata), .csr_wren(csr_wren),
        .csr_wraddr(csr_wraddr), .csr_wrdata(csr_wrdata),
        .hold(hold), .jump_en(jump_en), .jump_addr(jump_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR file stand-in: registered read, bench back-door preload has priority.
    logic [31:0] csr_mem [0:4095];
    logic        bk_we;
    logic [11:0] bk_addr;
    logic [31:0] bk_data;
    int          wr_count;

    initial wr_count = 0;
    always @(posedge clk) begin
        if (bk_we) begin
            csr_mem[bk_addr] <= bk_data;
        end else if (csr_wren) begin
            csr_mem[csr_wraddr] <= csr_wrdata;
            wr_count <= wr_count + 1;
        end
        csr_rddata <= csr_mem[csr_rdaddr];
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        exc_valid       = 1'b0;
        exc_code        = 4'd0;
        exc_pc          = 32'h0;
        mret_valid      = 1'b0;
        irq             = 1'b0;
        irq_pc          = 32'h0;
        glb_int_en      = 1'b0;
        core_csr_rdaddr = 12'h0;
        core_csr_wren   = 1'b0;
        core_csr_wraddr = 12'h0;
        core_csr_wrdata = 32'h0;
    endtask

    // Called and returns just after a falling edge.
    task automatic preload(input logic [11:0] addr, input logic [31:0] data);
        bk_we   = 1'b1;
        bk_addr = addr;
        bk_data = data;
        @(negedge clk);
        bk_we   = 1'b0;
    endtask

    // Sample one cycle's outputs before the rising edge, then move to the next cycle.
    // exp_hold < 0 means hold is not compared in this cycle.
    task automatic expect_cycle(input string name, input int exp_hold, input logic exp_wren,
                                input logic [11:0] exp_waddr, input logic [31:0] exp_wdata,
                                input logic exp_jen, input logic [31:0] exp_jaddr);
        #3;
        if (exp_hold >= 0) check({name, "_hold"}, 32'(hold), 32'(exp_hold));
        check({name, "_wren"}, 32'(csr_wren), 32'(exp_wren));
        if (exp_wren) begin
            check({name, "_waddr"}, 32'(csr_wraddr), 32'(exp_waddr));
            check({name, "_wdata"}, csr_wrdata, exp_wdata);
        end
        check({name, "_jen"}, 32'(jump_en), 32'(exp_jen));
        if (exp_jen) check({name, "_jaddr"}, jump_addr, exp_jaddr);
        @(negedge clk);
    endtask

    // Run with idle inputs until the redirect appears, bounded by budget cycles.
    task automatic wait_jump(input string name, input int budget, output logic [31:0] jaddr);
        logic seen;
        seen  = 1'b0;
        jaddr = 32'h0;
        for (int c = 0; c < budget && !seen; c++) begin
            #3;
            if (jump_en) begin
                seen  = 1'b1;
                jaddr = jump_addr;
            end
            @(negedge clk);
        end
        check({name, "_jump_seen"}, 32'(seen), 32'h1);
    endtask

    typedef struct {
        logic        exc;
        logic        mret;
        logic        irq;
        logic        glb;
        logic        cwren;
        logic [11:0] cwaddr;
        logic [31:0] cwdata;
        logic [11:0] crdaddr;
        logic        exp_hold;
        logic        exp_wren;
    } vec_t;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    vec_t vecs[7];
    wr_t  exp_q[$];
    wr_t  got_q[$];

    initial begin
        logic [31:0] ja;
        logic [31:0] ms, tv, ep, pc, cause, target;
        logic [3:0]  code;
        int          kind;
        int          wr_before;
        logic        seen;
        logic [31:0] jaddr_seen;

        n_checks = 0;
        n_errors = 0;
        bk_we    = 1'b0;
        bk_addr  = 12'h0;
        bk_data  = 32'h0;
        idle_inputs();
        rst_n = 1'b0;

        // ---------------- reset state ----------------
        @(negedge clk);
        @(negedge clk);
        #3;
        check("rst_hold", 32'(hold), 32'h0);
        check("rst_jen", 32'(jump_en), 32'h0);
        check("rst_jaddr", jump_addr, 32'h0);
        check("rst_wren", 32'(csr_wren), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        preload(A_MSTATUS, 32'h8);
        preload(A_MTVEC, 32'h200);
        preload(A_MEPC, 32'h80);

        // ---------------- table: idle pass-through and take cycles ----------------
        //          exc   mret  irq   glb   wren  waddr       wdata           rdaddr  hold  wren
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, A_MSCRATCH, 32'hA5A5_0000, 12'h300, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123,    32'h0,         12'h305, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h7C0,    32'h0000_1234, 12'h341, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h7C1,    32'hCAFE_0001, 12'h342, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h7C2,    32'h1111_1111, 12'h300, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h7C3,    32'h2222_2222, 12'h300, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h7C4,    32'h3333_3333, 12'h300, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            exc_valid       = vecs[i].exc;
            exc_code        = 4'd11;
            exc_pc          = 32'h0000_0100;
            mret_valid      = vecs[i].mret;
            irq             = vecs[i].irq;
            irq_pc          = 32'h0000_0104;
            glb_int_en      = vecs[i].glb;
            core_csr_wren   = vecs[i].cwren;
            core_csr_wraddr = vecs[i].cwaddr;
            core_csr_wrdata = vecs[i].cwdata;
            core_csr_rdaddr = vecs[i].crdaddr;
            #3;
            check($sformatf("vec%0d_hold", i), 32'(hold), 32'(vecs[i].exp_hold));
            check($sformatf("vec%0d_wren", i), 32'(csr_wren), 32'(vecs[i].exp_wren));
            if (vecs[i].exp_wren) begin
                check($sformatf("vec%0d_waddr", i), 32'(csr_wraddr), 32'(vecs[i].cwaddr));
                check($sformatf("vec%0d_wdata", i), csr_wrdata, vecs[i].cwdata);
            end
            if (!vecs[i].exp_hold) begin
                check($sformatf("vec%0d_rdaddr", i), 32'(csr_rdaddr), 32'(vecs[i].crdaddr));
            end
            check($sformatf("vec%0d_rddata_pass", i), core_csr_rddata, csr_rddata);
            @(negedge clk);
            idle_inputs();
            if (vecs[i].exp_hold) wait_jump($sformatf("vec%0d", i), 8, ja);
        end

        // ---------------- ecall trap sequence ----------------
        preload(A_MTVEC, 32'h0000_0200);
        preload(A_MSTATUS, 32'h0000_0008);
        exc_valid = 1'b1;
        exc_code  = 4'd11;
        exc_pc    = 32'h0000_0100;
        expect_cycle("exc_T0", 1, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
        idle_inputs();
        expect_cycle("exc_T1", 1, 1'b1, A_MEPC, 32'h0000_0100, 1'b0, 32'h0);
        expect_cycle("exc_T2", 1, 1'b1, A_MCAUSE, 32'h0000_000B, 1'b0, 32'h0);
        expect_cycle("exc_T3", 1, 1'b1, A_MSTATUS, 32'h0000_1880, 1'b0, 32'h0);
        expect_cycle("exc_T4", -1, 1'b0, 12'h0, 32'h0, 1'b1, 32'h0000_0200);
        #3;
        check("exc_T5_hold", 32'(hold), 32'h0);
        check("exc_T5_jen", 32'(jump_en), 32'h0);
        check("exc_T5_jaddr_held", jump_addr, 32'h0000_0200);
        @(negedge clk);

        // ---------------- mret sequence ----------------
        mret_valid = 1'b1;
        expect_cycle("mret_T0", 1, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
        idle_inputs();
        expect_cycle("mret_T1", 1, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
        expect_cycle("mret_T2", 1, 1'b1, A_MSTATUS, 32'h0000_1888, 1'b0, 32'h0);
        expect_cycle("mret_T3", -1, 1'b0, 12'h0, 32'h0, 1'b1, 32'h0000_0100);
        #3;
        check("mret_T4_hold", 32'(hold), 32'h0);
        check("mret_T4_jaddr_held", jump_addr, 32'h0000_0100);
        @(negedge clk);

        // ---------------- gated interrupt, then enabled ----------------
        irq    = 1'b1;
        irq_pc = 32'h0000_0444;
        for (int i = 0; i < 10; i++) begin
            expect_cycle($sformatf("irq_gated%0d", i), 0, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
        end
        glb_int_en = 1'b1;
        expect_cycle("irq_T0", 1, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
        irq        = 1'b0;
        glb_int_en = 1'b0;
        expect_cycle("irq_T1", 1, 1'b1, A_MEPC, 32'h0000_0444, 1'b0, 32'h0);
        expect_cycle("irq_T2", 1, 1'b1, A_MCAUSE, 32'h8000_0007, 1'b0, 32'h0);
        expect_cycle("irq_T3", 1, 1'b1, A_MSTATUS, 32'h0000_1880, 1'b0, 32'h0);
        expect_cycle("irq_T4", -1, 1'b0, 12'h0, 32'h0, 1'b1, 32'h0000_0200);
        idle_inputs();

        // ---------------- all requests plus a core write together ----------------
        preload(A_MSCRATCH, 32'hA5A5_0000);
        exc_valid       = 1'b1;
        exc_code        = 4'd2;
        exc_pc          = 32'h0000_0300;
        mret_valid      = 1'b1;
        irq             = 1'b1;
        glb_int_en      = 1'b1;
        irq_pc          = 32'h0000_0999;
        core_csr_wren   = 1'b1;
        core_csr_wraddr = A_MSCRATCH;
        core_csr_wrdata = 32'hDEAD_BEEF;
        expect_cycle("all_T0", 1, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
        idle_inputs();
        expect_cycle("all_T1", 1, 1'b1, A_MEPC, 32'h0000_0300, 1'b0, 32'h0);
        expect_cycle("all_T2", 1, 1'b1, A_MCAUSE, 32'h0000_0002, 1'b0, 32'h0);
        wait_jump("all", 6, ja);
        check("all_jaddr", ja, 32'h0000_0200);
        check("all_mscratch_kept", csr_mem[A_MSCRATCH], 32'hA5A5_0000);

        // ---------------- reset during T_MCAUSE ----------------
        exc_valid = 1'b1;
        exc_code  = 4'd3;
        exc_pc    = 32'h0000_0500;
        expect_cycle("rstmid_T0", 1, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
        idle_inputs();
        expect_cycle("rstmid_T1", 1, 1'b1, A_MEPC, 32'h0000_0500, 1'b0, 32'h0);
        #3;
        check("rstmid_T2_waddr", 32'(csr_wraddr), 32'(A_MCAUSE));
        #0.5;
        rst_n = 1'b0;
        #0.5;
        check("rstmid_hold", 32'(hold), 32'h0);
        check("rstmid_jen", 32'(jump_en), 32'h0);
        check("rstmid_wren", 32'(csr_wren), 32'h0);
        check("rstmid_jaddr", jump_addr, 32'h0);
        wr_before = wr_count;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expect_cycle($sformatf("rstmid_after%0d", i), 0, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
        end
        check("rstmid_no_writes", 32'(wr_count - wr_before), 32'h0);

        // ---------------- mtvec mode bits: vectored interrupt vs base ----------------
        preload(A_MTVEC, 32'h0000_0201);
        preload(A_MSTATUS, 32'h0000_0008);
        irq        = 1'b1;
        glb_int_en = 1'b1;
        irq_pc     = 32'h0000_0600;
        expect_cycle("vec_irq_T0", 1, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
        idle_inputs();
        wait_jump("vec_irq", 6, ja);
`ifdef TRAP_VECTORED_EN
        check("vec_irq_jaddr", ja, 32'h0000_021C);
`else
        check("vec_irq_jaddr", ja, 32'h0000_0200);
`endif
        exc_valid = 1'b1;
        exc_code  = 4'd2;
        exc_pc    = 32'h0000_0700;
        expect_cycle("vec_exc_T0", 1, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
        idle_inputs();
        wait_jump("vec_exc", 6, ja);
        check("vec_exc_jaddr", ja, 32'h0000_0200);

        // ---------------- random episodes against a transaction model ----------------
        for (int e = 0; e < 60; e++) begin
            ms = $urandom;
            tv = $urandom;
            ep = $urandom;
            preload(A_MSTATUS, ms);
            preload(A_MTVEC, tv);
            preload(A_MEPC, ep);
            case ($urandom_range(0, 2))
                0:       code = 4'd2;
                1:       code = 4'd3;
                default: code = 4'd11;
            endcase
            exc_valid       = ($urandom_range(0, 3) == 0);
            exc_code        = code;
            exc_pc          = $urandom;
            mret_valid      = ($urandom_range(0, 3) == 0);
            irq             = (($urandom & 1) != 0);
            irq_pc          = $urandom;
            glb_int_en      = (($urandom & 1) != 0);
            core_csr_wren   = (($urandom & 1) != 0);
            core_csr_wraddr = 12'($urandom);
            core_csr_wrdata = $urandom;
            core_csr_rdaddr = 12'($urandom);

            // Model: decide the accepted request and list the CSR writes and target it implies.
            kind = exc_valid ? 1 : mret_valid ? 2 : (irq && glb_int_en) ? 3 : 0;
            exp_q.delete();
            got_q.delete();
            target = 32'h0;
            if (kind == 1 || kind == 3) begin
                pc     = (kind == 1) ? exc_pc : irq_pc;
                cause  = (kind == 1) ? {28'h0, exc_code} : IRQ_CAUSE;
                exp_q.push_back('{A_MEPC, pc});
                exp_q.push_back('{A_MCAUSE, cause});
                exp_q.push_back('{A_MSTATUS, (ms & ~32'h1888) | (((ms >> 3) & 32'h1) << 7) | 32'h1800});
                target = tv & ~32'h3;
`ifdef TRAP_VECTORED_EN
                if (kind == 3 && (tv & 32'h3) == 32'h1) target = target + ((IRQ_CAUSE & 32'hF) << 2);
`endif
            end else if (kind == 2) begin
                exp_q.push_back('{A_MSTATUS, (ms & ~32'h88) | (((ms >> 7) & 32'h1) << 3) | 32'h80});
                target = ep & ~32'h3;
            end

            if (kind == 0) begin
                #3;
                check($sformatf("rnd%0d_idle_hold", e), 32'(hold), 32'h0);
                check($sformatf("rnd%0d_idle_wren", e), 32'(csr_wren), 32'(core_csr_wren));
                if (core_csr_wren) begin
                    check($sformatf("rnd%0d_idle_waddr", e), 32'(csr_wraddr), 32'(core_csr_wraddr));
                    check($sformatf("rnd%0d_idle_wdata", e), csr_wrdata, core_csr_wrdata);
                end
                @(negedge clk);
                idle_inputs();
            end else begin
                seen       = 1'b0;
                jaddr_seen = 32'h0;
                for (int c = 0; c < 10 && !seen; c++) begin
                    if (c > 0) begin
                        // Requests and core writes while busy must all be ignored.
                        exc_valid       = (($urandom & 1) != 0);
                        mret_valid      = (($urandom & 1) != 0);
                        irq             = (($urandom & 1) != 0);
                        glb_int_en      = (($urandom & 1) != 0);
                        core_csr_wren   = (($urandom & 1) != 0);
                        core_csr_wraddr = 12'($urandom);
                        core_csr_wrdata = $urandom;
                    end
                    #3;
                    if (!jump_en) check($sformatf("rnd%0d_hold_c%0d", e, c), 32'(hold), 32'h1);
                    if (csr_wren) got_q.push_back('{csr_wraddr, csr_wrdata});
                    if (jump_en) begin
                        seen       = 1'b1;
                        jaddr_seen = jump_addr;
                    end
                    @(negedge clk);
                end
                idle_inputs();
                check($sformatf("rnd%0d_jump_seen", e), 32'(seen), 32'h1);
                check($sformatf("rnd%0d_jaddr", e), jaddr_seen, target);
                check($sformatf("rnd%0d_nwrites", e), 32'(got_q.size()), 32'(exp_q.size()));
                for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
                    check($sformatf("rnd%0d_w%0d_addr", e, k), 32'(got_q[k].a), 32'(exp_q[k].a));
                    check($sformatf("rnd%0d_w%0d_data", e, k), got_q[k].d, exp_q[k].d);
                end
                #3;
                check($sformatf("rnd%0d_jen_once", e), 32'(jump_en), 32'h0);
                check($sformatf("rnd%0d_back_idle", e), 32'(hold), 32'h0);
                @(negedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
